// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key debouncer.
// Optional long-press logic is enabled by KEY_DEBOUNCE_LONG_PRESS_EN.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } kd_state_t;

    localparam logic KEY_PRESSED = 1'b0;

    function automatic int kd_cnt_w(input int d, input int l);
        int m;
        m = (d > l) ? d : l;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Button-side and consumer-side signals of the key debouncer.
// Long-press output is live only with KEY_DEBOUNCE_LONG_PRESS_EN.
interface key_debounce_if;

    logic key_raw;
    logic key_clean;
    logic press_pulse;
    logic release_pulse;
    logic long_press;
    logic busy;

    modport master (
        output key_raw,
        input  key_clean,
        input  press_pulse,
        input  release_pulse,
        input  long_press,
        input  busy
    );

    modport slave (
        input  key_raw,
        output key_clean,
        output press_pulse,
        output release_pulse,
        output long_press,
        output busy
    );

endinterface

// File: rtl/key_debounce_sync.sv
// Two-flop synchroniser for the raw button pin.
// Reset value is a parameter so the idle level is seen during reset.
module key_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= RST_VAL;
            sync_q2 <= RST_VAL;
        end else begin
            sync_q1 <= d_i;
            sync_q2 <= sync_q1;
        end
    end

    assign q_o = sync_q2;

endmodule

// File: rtl/key_debounce.sv
// Counter-based debouncer with press/release strobes and busy flag.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to add the long-press strobe.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic           clk,
    input  logic           reset_n,
    key_debounce_if.slave  kd
);

    localparam int W = kd_cnt_w(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [W-1:0] DEB = W'(DEBOUNCE_CYCLES);

    logic      key_s;
    logic      pressed;
    kd_state_t state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic      clean_q, clean_d;
    logic      press_q, press_d;
    logic      rel_q, rel_d;
    logic      busy_q, busy_d;

    key_sync #(.RST_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (kd.key_raw),
        .q_o     (key_s)
    );

    assign pressed = (key_s == KEY_PRESSED);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB) begin
                    state_d = PRESSED;
                    clean_d = KEY_PRESSED;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB) begin
                    state_d = RELEASED;
                    clean_d = ~KEY_PRESSED;
                    rel_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            clean_q <= 1'b1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            busy_q  <= busy_d;
        end
    end

    assign kd.key_clean     = clean_q;
    assign kd.press_pulse   = press_q;
    assign kd.release_pulse = rel_q;
    assign kd.busy          = busy_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam logic [W-1:0] LNG = W'(LONG_CYCLES);

    logic [W-1:0] hold_q, hold_d;
    logic         long_q, long_d;

    // Hold time survives a rejected release bounce; saturation blocks repeats.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if ((state_d == RELEASED) || press_d) begin
            hold_d = '0;
        end else if (((state_q == PRESSED) || (state_q == RELEASE_WAIT))
                     && (hold_q != LNG)) begin
            hold_d = hold_q + W'(1);
            long_d = (hold_d == LNG);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign kd.long_press = long_q;
`else
    assign kd.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: vector table plus strobe scoreboard.
// Long-press expectations follow KEY_DEBOUNCE_LONG_PRESS_EN.
module tb_key_debounce;

    localparam int D = 8;
    localparam int L = 40;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    key_debounce_if kd_if ();

    key_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kd      (kd_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int kind;
    } exp_t;

    typedef struct {
        logic raw;
        int   hold;
        bit   accept;
        logic clean;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[15];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        int n;
        int k;
        exp_t e;
        n = int'(kd_if.press_pulse) + int'(kd_if.release_pulse)
            + int'(kd_if.long_press);
        if (n > 1) chk("strobe_exclusive", n, 1);
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk($sformatf("missing_strobe_k%0d_at%0d", sb[0].kind, sb[0].cyc),
                0, 1);
            void'(sb.pop_front());
        end
        if (n > 0) begin
            k = kd_if.press_pulse ? 0 : (kd_if.release_pulse ? 1 : 2);
            if (sb.size() == 0) begin
                chk("unexpected_strobe_kind", k, -1);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", k, e.kind);
                chk("strobe_cyc", cyc, e.cyc);
            end
        end
    end

    // Called #1 after a rising edge; a change here is sampled on the next edge.
    task automatic drive(input logic v, input int hold, input bit acc,
                         input logic exp_clean, input string nm);
        int n0;
        kd_if.key_raw = v;
        n0 = cyc;
        if (acc) sb.push_back('{n0 + D + 3, (v ? 1 : 0)});
        repeat (hold) @(posedge clk);
        #1;
        chk(nm, int'(kd_if.key_clean), int'(exp_clean));
    endtask

    initial begin
        int n0;
        int p;

        tbl[0]  = '{1'b0,  5, 1'b0, 1'b1};
        tbl[1]  = '{1'b1,  2, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 12, 1'b1, 1'b0};
        tbl[3]  = '{1'b1,  3, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 10, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 12, 1'b1, 1'b1};
        tbl[6]  = '{1'b1,  4, 1'b0, 1'b1};
        tbl[7]  = '{1'b0,  8, 1'b0, 1'b1};
        tbl[8]  = '{1'b1,  4, 1'b0, 1'b1};
        tbl[9]  = '{1'b0,  9, 1'b1, 1'b1};
        tbl[10] = '{1'b0,  4, 1'b0, 1'b0};
        tbl[11] = '{1'b1,  8, 1'b0, 1'b0};
        tbl[12] = '{1'b0,  4, 1'b0, 1'b0};
        tbl[13] = '{1'b1,  9, 1'b1, 1'b0};
        tbl[14] = '{1'b1,  4, 1'b0, 1'b1};

        kd_if.key_raw = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clean", int'(kd_if.key_clean), 1);
        chk("rst_press", int'(kd_if.press_pulse), 0);
        chk("rst_release", int'(kd_if.release_pulse), 0);
        chk("rst_long", int'(kd_if.long_press), 0);
        chk("rst_busy", int'(kd_if.busy), 0);
        reset_n = 1'b1;

        // Idle after power-up: nothing may happen.
        repeat (100) @(posedge clk);
        #1;
        chk("idle_clean", int'(kd_if.key_clean), 1);
        chk("idle_busy", int'(kd_if.busy), 0);

        // Clean press with busy window, then a held press for long_press.
        kd_if.key_raw = 1'b0;
        n0 = cyc;
        p = n0 + D + 3;
        sb.push_back('{p, 0});
        if (LONG_EN) sb.push_back('{p + L, 2});
        for (int i = 1; i <= D + 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("busy_e%0d", i), int'(kd_if.busy),
                int'(i >= 3 && i <= D + 2));
        end
        chk("press_clean", int'(kd_if.key_clean), 0);
        repeat (60) @(posedge clk);
        #1;
        chk("long_hold_clean", int'(kd_if.key_clean), 0);
        drive(1'b1, 12, 1'b1, 1'b1, "long_release");

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].raw, tbl[i].hold, tbl[i].accept, tbl[i].clean,
                  $sformatf("vec%0d_clean", i));
        end

        // Reset in PRESS_WAIT at count 5 discards timing.
        kd_if.key_raw = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("midwait_busy", int'(kd_if.busy), 1);
        reset_n = 1'b0;
        #1;
        chk("rstwait_clean", int'(kd_if.key_clean), 1);
        chk("rstwait_busy", int'(kd_if.busy), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        n0 = cyc;
        sb.push_back('{n0 + D + 3, 0});
        repeat (D + 2) @(posedge clk);
        #1;
        chk("rewait_not_yet", int'(kd_if.key_clean), 1);
        @(posedge clk);
        #1;
        chk("rewait_clean", int'(kd_if.key_clean), 0);

        // Reset while pressed: clean returns high, no release strobe.
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rstpress_clean", int'(kd_if.key_clean), 1);
        kd_if.key_raw = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rstpress_after", int'(kd_if.key_clean), 1);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
